spu_load_store_unit: RTL and testbench

Load/store issue stage sitting directly upstream of the SPU quadword data memory. Accepts one quadword load or store per request from the execute stage, forms the effective address, and drives the memory's address/write-data/write/read strobes. It also captures the memory's registered read data and returns it with the destination register tag over a valid/ready response channel. The unit handles one outstanding operation at a time.

---
 rtl/spu_load_store_unit.sv | 138 +++++++++++++
 tb/tb_spu_load_store_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/spu_load_store_unit.sv
// Quadword load/store issue stage in front of the SPU data memory; one operation in flight.
// Optional macro LSU_RANGE_CHK_EN suppresses strobes for out-of-range addresses and flags rsp_err.
module spu_load_store_unit #(
  parameter int unsigned LS_DEPTH = 2001,
  parameter int unsigned TAG_W    = 7
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_store,
  input  logic [31:0]      i_req_base,
  input  logic [9:0]       i_req_offset,
  input  logic [127:0]     i_req_wdata,
  input  logic [TAG_W-1:0] i_req_tag,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_store,
  output logic [127:0]     o_rsp_data,
  output logic [TAG_W-1:0] o_rsp_tag,
  output logic             o_rsp_err,
  output logic [31:0]      o_mem_address,
  output logic [127:0]     o_mem_write_data,
  output logic             o_mem_write,
  output logic             o_mem_read,
  input  logic [127:0]     i_mem_read_data
);

`ifdef LSU_RANGE_CHK_EN
  localparam bit RangeChk = 1'b1;
`else
  localparam bit RangeChk = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e             r_state;
  logic               r_req_ready;
  logic               r_store;
  logic               r_oor;
  logic [TAG_W-1:0]   r_tag;
  logic               r_rsp_valid;
  logic               r_rsp_store;
  logic [127:0]       r_rsp_data;
  logic [TAG_W-1:0]   r_rsp_tag;
  logic               r_rsp_err;
  logic [31:0]        r_mem_address;
  logic [127:0]       r_mem_write_data;
  logic               r_mem_write;
  logic               r_mem_read;

  logic [31:0]        w_ea;
  logic               w_oor;

  // Offset counts quadwords; the sum wraps modulo 2^32.
  assign w_ea  = (i_req_base + {{18{i_req_offset[9]}}, i_req_offset, 4'b0000}) & 32'hFFFF_FFF0;
  assign w_oor = RangeChk && ({4'b0000, w_ea[31:4]} >= LS_DEPTH);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= StIdle;
      r_req_ready      <= 1'b0;
      r_store          <= 1'b0;
      r_oor            <= 1'b0;
      r_tag            <= '0;
      r_rsp_valid      <= 1'b0;
      r_rsp_store      <= 1'b0;
      r_rsp_data       <= '0;
      r_rsp_tag        <= '0;
      r_rsp_err        <= 1'b0;
      r_mem_address    <= '0;
      r_mem_write_data <= '0;
      r_mem_write      <= 1'b0;
      r_mem_read       <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          // Ready rises one edge after reset; an accept needs ready already high.
          if (r_req_ready && i_req_valid) begin
            r_req_ready      <= 1'b0;
            r_store          <= i_req_store;
            r_oor            <= w_oor;
            r_tag            <= i_req_tag;
            r_mem_address    <= w_ea;
            r_mem_write_data <= i_req_wdata;
            r_mem_write      <= i_req_store & ~w_oor;
            r_mem_read       <= ~i_req_store & ~w_oor;
            r_state          <= StIssue;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        StIssue: begin
          r_mem_write <= 1'b0;
          r_mem_read  <= 1'b0;
          if (r_store || r_oor) begin
            r_rsp_valid <= 1'b1;
            r_rsp_store <= r_store;
            r_rsp_data  <= '0;
            r_rsp_tag   <= r_tag;
            r_rsp_err   <= r_oor;
            r_state     <= StResp;
          end else begin
            r_state <= StWait;
          end
        end
        StWait: begin
          r_rsp_valid <= 1'b1;
          r_rsp_store <= 1'b0;
          r_rsp_data  <= i_mem_read_data;
          r_rsp_tag   <= r_tag;
          r_rsp_err   <= 1'b0;
          r_state     <= StResp;
        end
        StResp: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_req_ready      = r_req_ready;
  assign o_rsp_valid      = r_rsp_valid;
  assign o_rsp_store      = r_rsp_store;
  assign o_rsp_data       = r_rsp_data;
  assign o_rsp_tag        = r_rsp_tag;
  assign o_rsp_err        = r_rsp_err;
  assign o_mem_address    = r_mem_address;
  assign o_mem_write_data = r_mem_write_data;
  assign o_mem_write      = r_mem_write;
  assign o_mem_read       = r_mem_read;

endmodule

// File: tb/tb_spu_load_store_unit.sv
// Bench for spu_load_store_unit: table of requests checked against a reference memory and
// a response scoreboard, plus reset, backpressure and reset-in-WAIT sequences.
module tb_spu_load_store_unit;
  localparam int unsigned D  = 2001;
  localparam int unsigned TW = 7;
`ifdef LSU_RANGE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    bit           st;
    logic [31:0]  base;
    logic [9:0]   off;
    logic [127:0] wd;
    logic [TW-1:0] tag;
    logic [31:0]  addr;
    int           bp;
  } vec_t;

  typedef struct {
    bit           st;
    logic [127:0] data;
    logic [TW-1:0] tag;
    bit           err;
  } rsp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_store = 1'b0;
  logic [31:0]    req_base = '0;
  logic [9:0]     req_offset = '0;
  logic [127:0]   req_wdata = '0;
  logic [TW-1:0]  req_tag = '0;
  logic           rsp_ready = 1'b1;
  logic           req_ready, rsp_valid, rsp_store, rsp_err, mem_write, mem_read;
  logic [127:0]   rsp_data, mem_write_data;
  logic [TW-1:0]  rsp_tag;
  logic [31:0]    mem_address;
  logic [127:0]   mem_read_data;

  logic [127:0]   mem [D];
  logic [127:0]   ref_mem [D];
  rsp_t           sb[$];
  vec_t           vecs[10];
  int             total = 0;
  int             bad = 0;

  spu_load_store_unit #(.LS_DEPTH(D), .TAG_W(TW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_store(req_store),
    .i_req_base(req_base), .i_req_offset(req_offset), .i_req_wdata(req_wdata),
    .i_req_tag(req_tag),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_store(rsp_store),
    .o_rsp_data(rsp_data), .o_rsp_tag(rsp_tag), .o_rsp_err(rsp_err),
    .o_mem_address(mem_address), .o_mem_write_data(mem_write_data),
    .o_mem_write(mem_write), .o_mem_read(mem_read), .i_mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Registered quadword memory; out-of-range indices read as 0 and ignore writes.
  wire [27:0] m_idx = mem_address[31:4];
  always @(posedge clk) begin
    if (mem_write === 1'b1 && {4'b0, m_idx} < D) mem[m_idx] <= mem_write_data;
    mem_read_data <= (mem_read === 1'b1 && {4'b0, m_idx} < D) ? mem[m_idx] : '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_req(input vec_t v, input string nm);
    bit acc;
    int k;
    rsp_t e, g;
    logic [27:0] idx;
    bit in_rng;
    idx    = v.addr[31:4];
    in_rng = ({4'b0, idx} < D);
    e.st   = v.st;
    e.tag  = v.tag;
    e.err  = CHK && !in_rng;
    e.data = (v.st || !in_rng) ? '0 : ref_mem[idx];
    rsp_ready  = (v.bp == 0);
    req_store  = v.st;
    req_base   = v.base;
    req_offset = v.off;
    req_wdata  = v.wd;
    req_tag    = v.tag;
    req_valid  = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      acc = req_ready;
      tick();
    end
    req_valid = 1'b0;
    if (!acc) begin
      chk({nm, "_accept"}, 0, 1);
      return;
    end
    chk({nm, "_addr"}, mem_address, v.addr);
    chk({nm, "_strobe"}, {req_ready, mem_write, mem_read},
        {1'b0, v.st && !e.err, !v.st && !e.err});
    if (v.st && !e.err) chk({nm, "_wdata"}, mem_write_data, v.wd);
    sb.push_back(e);
    if (v.st && in_rng) ref_mem[idx] = v.wd;
    tick();
    k = 1;
    chk({nm, "_strobe_off"}, {mem_write, mem_read}, 2'b00);
    while (!rsp_valid && k < 10) begin
      tick();
      k++;
    end
    chk({nm, "_latency"}, k, (v.st || e.err) ? 1 : 2);
    if (!rsp_valid) return;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 0, 1);
      return;
    end
    g = sb.pop_front();
    chk({nm, "_rsp_ctrl"}, {rsp_store, rsp_err}, {g.st, g.err});
    chk({nm, "_rsp_data"}, rsp_data, g.data);
    chk({nm, "_rsp_tag"}, rsp_tag, g.tag);
    for (int i = 0; i < v.bp; i++) begin
      tick();
      chk({nm, "_hold_ctrl"}, {rsp_valid, rsp_store, rsp_err, req_ready, mem_write, mem_read},
          {1'b1, g.st, g.err, 3'b000});
      chk({nm, "_hold_data"}, {rsp_tag, rsp_data}, {g.tag, g.data});
    end
    rsp_ready = 1'b1;
    tick();
    chk({nm, "_done"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0100, 10'd2,   128'd120,                 7'd1,   32'h0000_0120, 0};
    vecs[1] = '{1'b0, 32'h0000_012F, 10'd0,   128'd0,                   7'd5,   32'h0000_0120, 0};
    vecs[2] = '{1'b1, 32'h0000_1000, 10'h3FD, {4{32'hDEAD_BEEF}},       7'd9,   32'h0000_0FD0, 0};
    vecs[3] = '{1'b0, 32'h0000_0FD5, 10'd0,   128'd0,                   7'd127, 32'h0000_0FD0, 5};
    vecs[4] = '{1'b0, 32'h0000_0008, 10'h3FF, 128'd0,                   7'd2,   32'hFFFF_FFF0, 0};
    vecs[5] = '{1'b1, 32'h0000_7D00, 10'd0,   {2{64'h0123_4567_89AB_CDEF}}, 7'd4, 32'h0000_7D00, 0};
    vecs[6] = '{1'b0, 32'h0000_7CFC, 10'd1,   128'd0,                   7'd6,   32'h0000_7D00, 0};
    vecs[7] = '{1'b0, 32'h0000_7D10, 10'd0,   128'd0,                   7'd7,   32'h0000_7D10, 0};
    vecs[8] = '{1'b1, 32'h0000_0000, 10'h1FF, {16{8'hA5}},              7'd8,   32'h0000_1FF0, 0};
    vecs[9] = '{1'b0, 32'h0000_0010, 10'h1FE, 128'd0,                   7'd10,  32'h0000_1FF0, 2};
    for (int i = 0; i < int'(D); i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end

    // Reset held with a pending store request.
    rst       = 1'b1;
    req_valid = 1'b1;
    req_store = 1'b1;
    req_wdata = '1;
    req_base  = 32'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ctrl", {req_ready, rsp_valid, rsp_store, rsp_err, mem_write, mem_read}, 6'd0);
      chk("rst_rsp", {rsp_tag, rsp_data}, '0);
      chk("rst_mem", {mem_address, mem_write_data[95:0]}, '0);
    end
    rst       = 1'b0;
    req_valid = 1'b0;
    tick();
    chk("rst_ready", {req_ready, mem_write, mem_read, rsp_valid}, 4'b1000);

    for (int i = 0; i < 10; i++) do_req(vecs[i], $sformatf("v%0d", i));

    // Reset while a load waits for memory data.
    req_store  = 1'b0;
    req_base   = 32'h120;
    req_offset = '0;
    req_tag    = 7'd3;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("rw_accept", {req_ready, mem_read}, 2'b01);
    tick();
    rst = 1'b1;
    tick();
    chk("rw_rst", {rsp_valid, req_ready, mem_write, mem_read}, 4'b0000);
    rst = 1'b0;
    tick();
    chk("rw_ready", {req_ready, rsp_valid}, 2'b10);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rw_quiet", {rsp_valid, mem_read, mem_write}, 3'b000);
    end
    do_req('{1'b0, 32'h0000_0120, 10'd0, 128'd0, 7'd11, 32'h0000_0120, 0}, "rw_load");
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
